// File: rtl/accum_readout_controller_pkg.sv
// rtl/accum_readout_controller_pkg.sv - shared encodings and tile geometry for the readout controller
//
// Purpose: job-mode encodings (shared with the accumulation controller), tile
// geometry constants and the readout FSM state encoding.
package accum_readout_controller_pkg;

  localparam logic [1:0] CONV_MODE = 2'b00;
  localparam logic [1:0] FC_MODE   = 2'b01;

  localparam int TILE_ROW_W = 14;
  localparam int TILE_PIX   = TILE_ROW_W * TILE_ROW_W;  // 196
  localparam int POOL_W     = TILE_ROW_W / 2;           // 7
  localparam int POOL_PIX   = POOL_W * POOL_W;          // 49

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROW_A = 3'd1,
    ST_ROW_B = 3'd2,
    ST_FC_RD = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/accum_readout_controller_relu_requant.sv
// rtl/accum_readout_controller_relu_requant.sv - combinational ReLU, arithmetic shift and saturation
//
// Purpose: maps one signed accumulator word to a non-negative activation.
// Ports:
//   acc  in   ACC_W  signed accumulator value
//   act  out  OUT_W  activation: 0 if acc < 0, else min(acc >>> SHIFT, 2^(OUT_W-1)-1)
module accum_readout_controller_relu_requant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] act
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic [ACC_W-1:0] shifted;

  assign shifted = $signed(acc) >>> SHIFT;

  always_comb begin
    if (acc[ACC_W-1]) begin
      act = '0;
    end else if (shifted > SAT_MAX) begin
      act = SAT_MAX[OUT_W-1:0];
    end else begin
      act = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/accum_readout_controller.sv
// rtl/accum_readout_controller.sv - drains the partial-sum register file into an activation stream
//
// Purpose: each relu_activate request releases one row pair (CONV) or one
// scalar (FC); pixels go through ReLU/requant, optional 2x2 max-pool, and a
// valid/ready output register backed by a 1-entry skid.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   conv_or_fc, pool_en  job mode, sampled at job start
//   relu_activate        one-cycle job request
//   rd_en, rd_idx        register-file read strobe and pixel index
//   rd_data              register-file data, valid one cycle after rd_en
//   out_valid, out_ready output handshake
//   out_data, out_idx    activation and its index within the tile
//   tile_done            pulse after the last output of a tile or FC job
//   busy                 job active or request pending
//   overrun_err          sticky request-queue overflow
module accum_readout_controller
  import accum_readout_controller_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int ROW_W = TILE_ROW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       conv_or_fc,
  input  logic             pool_en,
  input  logic             relu_activate,
  output logic             rd_en,
  output logic [7:0]       rd_idx,
  input  logic [ACC_W-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [7:0]       out_idx,
  output logic             tile_done,
  output logic             busy,
  output logic             overrun_err
);

  localparam int               COL_W     = $clog2(ROW_W);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_W - 1);
  localparam logic [2:0]       PAIR_LAST = 3'(POOL_PIX / POOL_W - 1);

  state_t           state;
  logic [1:0]       pending;
  logic             fc_q;
  logic             pool_q;
  logic [COL_W-1:0] col_cnt;
  logic [2:0]       pair_cnt;

  // Stage 1: metadata of the read whose data is on rd_data this cycle.
  logic             s1_valid;
  logic             s1_rowb;
  logic [COL_W-1:0] s1_col;
  logic [7:0]       s1_idx;

  logic [OUT_W-1:0] held_max;
  logic [OUT_W-1:0] pool_buf [POOL_W];

  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [7:0]       skid_idx;

  logic             reading;
  logic             out_free;
  logic             start;
  logic             drain_done;
  logic [OUT_W-1:0] q;
  logic [OUT_W-1:0] pair_max;
  logic [OUT_W-1:0] buf_val;
  logic [OUT_W-1:0] pool_out;
  logic             emit_now;
  logic [OUT_W-1:0] emit_data;
  logic [7:0]       emit_idx;

  accum_readout_controller_relu_requant #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_requant (
    .acc(rd_data),
    .act(q)
  );

  assign reading  = (state == ST_ROW_A) || (state == ST_ROW_B) || (state == ST_FC_RD);
  assign out_free = !out_valid || out_ready;
  // Gated combinationally so a read is never launched into a blocked output:
  // whatever is in flight then always fits into the output register or skid.
  assign rd_en    = reading && out_free && !skid_valid;
  assign rd_idx   = (reading && !fc_q)
                    ? 8'({pair_cnt, state == ST_ROW_B}) * 8'(ROW_W) + 8'(col_cnt)
                    : 8'd0;
  assign busy     = (state != ST_IDLE) || (pending != 2'd0);

  assign start      = (state == ST_IDLE) && (pending != 2'd0);
  assign drain_done = (state == ST_DRAIN) && !s1_valid && !skid_valid && !out_valid;

  assign pair_max  = (held_max > q) ? held_max : q;
  assign buf_val   = pool_buf[s1_col[COL_W-1:1]];
  assign pool_out  = (pair_max > buf_val) ? pair_max : buf_val;
  // Pooled jobs emit only on the odd column of the second row.
  assign emit_now  = s1_valid && (!pool_q || (s1_rowb && s1_col[0]));
  assign emit_data = pool_q ? pool_out : q;
  assign emit_idx  = pool_q ? 8'(pair_cnt) * 8'(POOL_W) + 8'(s1_col[COL_W-1:1]) : s1_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= 2'd0;
      fc_q        <= 1'b0;
      pool_q      <= 1'b0;
      col_cnt     <= '0;
      pair_cnt    <= 3'd0;
      s1_valid    <= 1'b0;
      s1_rowb     <= 1'b0;
      s1_col      <= '0;
      s1_idx      <= 8'd0;
      held_max    <= '0;
      for (int i = 0; i < POOL_W; i++) pool_buf[i] <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_idx    <= 8'd0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= 8'd0;
      tile_done   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      tile_done <= 1'b0;

      // A pulse in the same cycle as a job start nets out against it.
      if (relu_activate && !start && (pending == 2'd2)) begin
        overrun_err <= 1'b1;
      end else begin
        pending <= pending + {1'b0, relu_activate} - {1'b0, start};
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            fc_q    <= (conv_or_fc == FC_MODE);
            pool_q  <= pool_en && (conv_or_fc == CONV_MODE);
            col_cnt <= '0;
            state   <= (conv_or_fc == FC_MODE) ? ST_FC_RD : ST_ROW_A;
          end
        end
        ST_ROW_A, ST_ROW_B: begin
          if (rd_en) begin
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              state   <= (state == ST_ROW_A) ? ST_ROW_B : ST_DRAIN;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        ST_FC_RD: begin
          if (rd_en) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_IDLE;
            if (fc_q) begin
              tile_done <= 1'b1;
            end else if (pair_cnt == PAIR_LAST) begin
              pair_cnt  <= 3'd0;
              tile_done <= 1'b1;
            end else begin
              pair_cnt <= pair_cnt + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      s1_valid <= rd_en;
      if (rd_en) begin
        s1_rowb <= (state == ST_ROW_B);
        s1_col  <= col_cnt;
        s1_idx  <= rd_idx;
      end

      if (s1_valid && pool_q) begin
        if (!s1_col[0]) begin
          held_max <= q;
        end else if (!s1_rowb) begin
          pool_buf[s1_col[COL_W-1:1]] <= pair_max;
        end
      end

      // The skid always drains first so output order is preserved.
      if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_idx    <= skid_idx;
          skid_valid <= emit_now;
          skid_data  <= emit_data;
          skid_idx   <= emit_idx;
        end else if (emit_now) begin
          out_valid <= 1'b1;
          out_data  <= emit_data;
          out_idx   <= emit_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (emit_now) begin
        skid_valid <= 1'b1;
        skid_data  <= emit_data;
        skid_idx   <= emit_idx;
      end
    end
  end

endmodule

// File: tb/tb_accum_readout_controller.sv
// tb/tb_accum_readout_controller.sv - scoreboard bench for accum_readout_controller
module tb_accum_readout_controller;

  logic        clk;
  logic        rst;
  logic [1:0]  conv_or_fc;
  logic        pool_en;
  logic        relu_activate;
  logic        rd_en;
  logic [7:0]  rd_idx;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_idx;
  logic        tile_done;
  logic        busy;
  logic        overrun_err;

  accum_readout_controller dut (
    .clk(clk), .rst(rst), .conv_or_fc(conv_or_fc), .pool_en(pool_en),
    .relu_activate(relu_activate), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .tile_done(tile_done), .busy(busy), .overrun_err(overrun_err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  i;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] mem [196];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tile_cnt = 0;
  int          acc_cnt = 0;
  int          first_acc = -1;
  int          last_acc = -1;
  int          lat_rd = -1;
  int          lat_ov = -1;
  logic        rf_pend = 1'b0;
  logic [7:0]  rf_idx = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-file model: data appears for exactly the cycle after rd_en.
  always @(negedge clk) begin
    rf_pend = rd_en;
    rf_idx  = rd_idx;
  end
  always @(posedge clk) begin
    #1;
    rd_data = (rf_pend && rf_idx < 8'd196) ? mem[rf_idx] : 32'h0012_3400;
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) chk("rd_en_while_blocked", {31'd0, out_valid && !out_ready}, 32'd0);
      if (rd_en && lat_rd < 0) lat_rd = cyc;
      if (out_valid && lat_ov < 0) lat_ov = cyc;
      if (out_valid && out_ready) begin
        chk("sb_not_empty", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, mon_e.d});
          chk("out_idx", {24'd0, out_idx}, {24'd0, mon_e.i});
        end
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (tile_done) begin
        tile_cnt++;
        chk("tile_done_after_last", sb_q.size(), 32'd0);
      end
    end
  end

  function automatic logic [15:0] model_rq(input logic [31:0] v);
    longint sv;
    longint s;
    sv = longint'($signed(v));
    if (sv < 0) return 16'd0;
    s = sv / 256;
    if (s > 32767) return 16'd32767;
    return 16'(s);
  endfunction

  task automatic push_exp(input logic [15:0] d, input int i);
    exp_t e;
    e.d = d;
    e.i = 8'(i);
    sb_q.push_back(e);
  endtask

  task automatic push_unpooled(input int p);
    for (int r = 2 * p; r < 2 * p + 2; r++)
      for (int c = 0; c < 14; c++) push_exp(model_rq(mem[r * 14 + c]), r * 14 + c);
  endtask

  task automatic push_pooled(input int p);
    logic [15:0] m;
    logic [15:0] v;
    for (int k = 0; k < 7; k++) begin
      m = 16'd0;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          v = model_rq(mem[(2 * p + dr) * 14 + 2 * k + dc]);
          if (v > m) m = v;
        end
      push_exp(m, p * 7 + k);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 196; i++) mem[i] = 32'(i * 256);
  endtask

  task automatic clear_stats();
    acc_cnt = 0; first_acc = -1; last_acc = -1; lat_rd = -1; lat_ov = -1; tile_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_idx"}, {24'd0, out_idx}, 32'd0);
    chk({tag, "_tile_done"}, {31'd0, tile_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; relu_activate = 1'b0; conv_or_fc = 2'b00; pool_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    clear_stats();
    rst = 1'b0;
  endtask

  task automatic pulse(input int n);
    @(posedge clk); #1;
    relu_activate = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    relu_activate = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit bp);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!busy && !out_valid && sb_q.size() == 0) done = 1'b1;
      n++;
    end
    chk({tag, "_completed"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  logic [31:0] edge_vals [9];
  logic [15:0] edge_exp [9];

  initial begin
    rst = 1'b1; relu_activate = 1'b0; conv_or_fc = 2'b00; pool_en = 1'b0;
    out_ready = 1'b1; rd_data = 32'd0;
    fill_ramp();
    @(negedge clk);
    check_zero_outputs("reset");

    // Unpooled pair 0; mode inputs flipped after start must be ignored.
    do_reset();
    push_unpooled(0);
    pulse(1);
    @(posedge clk); #1;
    pool_en = 1'b1; conv_or_fc = 2'b01;
    wait_idle("unpooled", 400, 1'b0);
    chk("unpooled_count", acc_cnt, 32'd28);
    chk("unpooled_back_to_back", last_acc - first_acc, 32'd27);
    chk("unpooled_latency", lat_ov - lat_rd, 32'd2);
    chk("unpooled_no_tile_done", tile_cnt, 32'd0);

    // Pooled: seven pairs, one tile_done after out_idx 48.
    do_reset();
    pool_en = 1'b1;
    for (int p = 0; p < 7; p++) begin
      push_pooled(p);
      pulse(1);
      wait_idle("pooled", 400, 1'b0);
      if (p == 5) chk("pooled_tile_before_last", tile_cnt, 32'd0);
    end
    chk("pooled_count", acc_cnt, 32'd49);
    chk("pooled_tile_done", tile_cnt, 32'd1);

    // Negative, overflow and shifted-out values.
    do_reset();
    fill_ramp();
    edge_vals = '{32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'd255, 32'd256, 32'h0080_0000,
                  32'h007F_FF00, 32'h007F_FFFF, 32'h8000_0000, 32'h0000_01FF};
    edge_exp  = '{16'd0, 16'd32767, 16'd0, 16'd1, 16'd32767,
                  16'd32767, 16'd32767, 16'd0, 16'd1};
    for (int i = 0; i < 9; i++) mem[i] = edge_vals[i];
    for (int i = 0; i < 28; i++) push_exp((i < 9) ? edge_exp[i] : 16'(i), i);
    pulse(1);
    wait_idle("edge", 400, 1'b0);
    chk("edge_count", acc_cnt, 32'd28);

    // Backpressure: random data, random out_ready.
    do_reset();
    for (int i = 0; i < 196; i++) mem[i] = $urandom() >> (i % 9);
    push_unpooled(0);
    pulse(1);
    wait_idle("bp_unpooled", 1000, 1'b1);
    chk("bp_unpooled_count", acc_cnt, 32'd28);
    pool_en = 1'b1;
    push_pooled(1);
    pulse(1);
    wait_idle("bp_pooled", 1000, 1'b1);
    chk("bp_total_count", acc_cnt, 32'd35);

    // Three requests while busy: two accepted, one dropped.
    do_reset();
    fill_ramp();
    push_unpooled(0);
    pulse(1);
    repeat (5) @(posedge clk);
    push_unpooled(1);
    push_unpooled(2);
    pulse(3);
    wait_idle("overrun", 1500, 1'b0);
    chk("overrun_flag", {31'd0, overrun_err}, 32'd1);
    chk("overrun_count", acc_cnt, 32'd84);

    // Request coinciding with job start: two jobs total, no overrun.
    do_reset();
    push_unpooled(0);
    push_unpooled(1);
    pulse(2);
    wait_idle("coincide", 1000, 1'b0);
    chk("coincide_no_overrun", {31'd0, overrun_err}, 32'd0);
    chk("coincide_count", acc_cnt, 32'd56);

    // FC jobs.
    do_reset();
    conv_or_fc = 2'b01; pool_en = 1'b1;
    mem[0] = 32'h0000_0300;
    push_exp(16'd3, 0);
    pulse(1);
    wait_idle("fc", 200, 1'b0);
    chk("fc_tile_done", tile_cnt, 32'd1);
    mem[0] = 32'hFFFF_FFFF;
    push_exp(16'd0, 0);
    pulse(1);
    wait_idle("fc_neg", 200, 1'b0);
    chk("fc_count", acc_cnt, 32'd2);
    chk("fc_tile_done_2", tile_cnt, 32'd2);

    // Reset in the middle of ROW_B, then a fresh job restarts at pair 0.
    do_reset();
    fill_ramp();
    push_unpooled(0);
    pulse(1);
    begin
      int  n;
      bit  hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 200) begin
        @(negedge clk);
        if (rd_en && rd_idx >= 8'd16) hit = 1'b1;
        n++;
      end
      chk("mid_reset_reached_row_b", {31'd0, hit}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_zero_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    push_unpooled(0);
    pulse(1);
    wait_idle("restart", 400, 1'b0);
    chk("restart_count", acc_cnt, 32'd28);
    chk("restart_no_tile_done", tile_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
